// File: rtl/prbs_ber_ctrl.sv
// prbs_ber_ctrl -- sequencer for one PRBS31 bit-error-rate run on the GTX
// receive path. It waits for link ready, acquires pattern sync and then
// accumulates bit errors over a programmed window of words.
//
// Ports
//   CLK, RSTn       rx user clock, asynchronous active-low reset
//   start, abort    run request / immediate stop (abort wins over everything)
//   link_ready      transceiver reset/alignment done (CLK domain)
//   window_len      measurement length in words, latched on accepted start
//   rx_bit_error    per-bit error word from the PRBS31 checker
//   state           IDLE=0 WAIT_READY=1 SYNC=2 MEASURE=3 DONE=4 FAIL=5
//   busy/done/fail  status flags, registered
//   err_count       accumulated error bits, saturating at 2^ERR_W-1
//   word_count      words measured in the current window
//   resync_count    sync losses during the run, saturating at 255
//
// ERR_W only exists so narrow instances can exercise saturation; leave it at 40.
module prbs_ber_ctrl #(
  parameter int SYNC_WORDS   = 64,
  parameter int LOSS_BITS    = 8,
  parameter int SYNC_TIMEOUT = 65535,
  parameter int ERR_W        = 40
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             start,
  input  logic             abort,
  input  logic             link_ready,
  input  logic [31:0]      window_len,
  input  logic [31:0]      rx_bit_error,
  output logic [2:0]       state,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      word_count,
  output logic [7:0]       resync_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_SYNC = 3'd2,
    S_MEAS = 3'd3,
    S_DONE = 3'd4,
    S_FAIL = 3'd5
  } st_e;

  localparam int                CW = $clog2(SYNC_WORDS + 1);
  localparam logic [CW-1:0]     SW = CW'(SYNC_WORDS);
  localparam logic [31:0]       TO = 32'(SYNC_TIMEOUT);
  localparam logic [6:0]        LB = 7'(LOSS_BITS);

  st_e              r_st, w_nxt;
  logic [31:0]      r_errq;
  logic [31:0]      r_win;
  logic [CW-1:0]    r_clean;
  logic [31:0]      r_to;
  logic [ERR_W-1:0] r_ec;
  logic [31:0]      r_wc;
  logic [7:0]       r_rs;
  logic             r_busy, r_done, r_fail;

  logic [5:0]       w_pc;
  logic [CW-1:0]    w_clean_upd;
  logic [31:0]      w_to_p1;
  logic [31:0]      w_wc_p1;
  logic [ERR_W:0]   w_ec_sum;
  logic [ERR_W-1:0] w_ec_sat;
  logic             w_loss_hit;
  logic             w_start_run, w_drop, w_acc, w_loss;

  always_comb begin
    w_pc = '0;
    for (int i = 0; i < 32; i++) w_pc = w_pc + {5'd0, r_errq[i]};
  end

  assign w_clean_upd = (r_errq == '0) ? r_clean + 1'b1 : '0;
  assign w_to_p1     = r_to + 32'd1;
  assign w_wc_p1     = r_wc + 32'd1;
  assign w_ec_sum    = {1'b0, r_ec} + (ERR_W+1)'(w_pc);
  assign w_ec_sat    = w_ec_sum[ERR_W] ? '1 : w_ec_sum[ERR_W-1:0];
  assign w_loss_hit  = {1'b0, w_pc} >= LB;

  always_comb begin
    w_nxt       = r_st;
    w_start_run = 1'b0;
    w_drop      = 1'b0;
    w_acc       = 1'b0;
    w_loss      = 1'b0;
    if (abort) begin
      w_nxt = S_IDLE;
    end else begin
      case (r_st)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            w_nxt       = S_WAIT;
            w_start_run = 1'b1;
          end
        end
        S_WAIT: if (link_ready) w_nxt = S_SYNC;
        S_SYNC: begin
          if (!link_ready) begin
            w_nxt  = S_WAIT;
            w_drop = 1'b1;
          end else if (w_clean_upd == SW) begin
            w_nxt = S_MEAS;   // sync beats a timeout on the same edge
          end else if (w_to_p1 == TO) begin
            w_nxt = S_FAIL;
          end
        end
        S_MEAS: begin
          if (!link_ready) begin
            w_nxt  = S_WAIT;
            w_drop = 1'b1;
          end else if (r_win == '0) begin
            w_nxt = S_DONE;
          end else if (w_loss_hit) begin
            // a lossy word is never counted, even if it was the last one
            w_nxt  = S_SYNC;
            w_loss = 1'b1;
          end else begin
            w_acc = 1'b1;
            if (w_wc_p1 == r_win) w_nxt = S_DONE;
          end
        end
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_st    <= S_IDLE;
      r_errq  <= '0;
      r_win   <= '0;
      r_clean <= '0;
      r_to    <= '0;
      r_ec    <= '0;
      r_wc    <= '0;
      r_rs    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_errq <= rx_bit_error;
      r_st   <= w_nxt;
      r_busy <= (w_nxt == S_WAIT) || (w_nxt == S_SYNC) || (w_nxt == S_MEAS);
      r_done <= (w_nxt == S_DONE);
      r_fail <= (w_nxt == S_FAIL);

      // clean/timeout counters only live while SYNC persists, so every
      // entry into SYNC starts them from zero
      if (r_st == S_SYNC && w_nxt == S_SYNC) begin
        r_clean <= w_clean_upd;
        r_to    <= w_to_p1;
      end else begin
        r_clean <= '0;
        r_to    <= '0;
      end

      if (w_start_run) r_win <= window_len;

      if (w_start_run || w_drop) begin
        r_ec <= '0;
        r_wc <= '0;
        r_rs <= '0;
      end else if (w_acc) begin
        r_ec <= w_ec_sat;
        r_wc <= w_wc_p1;
      end else if (w_loss) begin
        r_rs <= (r_rs == 8'hFF) ? r_rs : r_rs + 8'd1;
      end
    end
  end

  assign state        = r_st;
  assign busy         = r_busy;
  assign done         = r_done;
  assign fail         = r_fail;
  assign err_count    = r_ec;
  assign word_count   = r_wc;
  assign resync_count = r_rs;

endmodule

// File: tb/tb_prbs_ber_ctrl.sv
// Bench for prbs_ber_ctrl: directed vector table, hand-written corner
// sequences (timeout, mid-run reset), random traffic against a behavioural
// model, and a narrow-counter instance for err_count saturation.
module tb_prbs_ber_ctrl;

  localparam int SWD  = 12;
  localparam int LOSS = 8;
  localparam int TMO  = 200;
  localparam longint EC_MAX = (64'sd1 <<< 40) - 1;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        start = 1'b0, abort = 1'b0, link_ready = 1'b0;
  logic [31:0] window_len = '0, rx_bit_error = '0;
  logic [2:0]  state;
  logic        busy, done, fail;
  logic [39:0] err_count;
  logic [31:0] word_count;
  logic [7:0]  resync_count;

  logic        start2 = 1'b0, link_ready2 = 1'b0;
  logic [31:0] window_len2 = '0, rx_bit_error2 = '0;
  logic [2:0]  state2;
  logic        busy2, done2, fail2;
  logic [9:0]  err_count2;
  logic [31:0] word_count2;
  logic [7:0]  resync_count2;

  always #5 CLK = ~CLK;

  prbs_ber_ctrl #(.SYNC_WORDS(SWD), .LOSS_BITS(LOSS), .SYNC_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .abort(abort), .link_ready(link_ready),
    .window_len(window_len), .rx_bit_error(rx_bit_error), .state(state),
    .busy(busy), .done(done), .fail(fail), .err_count(err_count),
    .word_count(word_count), .resync_count(resync_count));

  prbs_ber_ctrl #(.SYNC_WORDS(SWD), .LOSS_BITS(33), .SYNC_TIMEOUT(TMO), .ERR_W(10)) dut2 (
    .CLK(CLK), .RSTn(RSTn), .start(start2), .abort(1'b0), .link_ready(link_ready2),
    .window_len(window_len2), .rx_bit_error(rx_bit_error2), .state(state2),
    .busy(busy2), .done(done2), .fail(fail2), .err_count(err_count2),
    .word_count(word_count2), .resync_count(resync_count2));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode values are the spec's state encoding
  int          m_st, m_clean, m_to, m_rs;
  longint      m_ec, m_wc, m_win;
  logic [31:0] m_errq;

  task automatic mreset();
    m_st = 0; m_clean = 0; m_to = 0; m_rs = 0;
    m_ec = 0; m_wc = 0; m_win = 0; m_errq = '0;
  endtask

  task automatic mstep(input logic s, input logic a, input logic l,
                       input logic [31:0] w, input logic [31:0] r);
    int pc;
    pc = $countones(m_errq);
    if (a) m_st = 0;
    else if (m_st == 0 || m_st == 4 || m_st == 5) begin
      if (s) begin m_st = 1; m_ec = 0; m_wc = 0; m_rs = 0; m_win = longint'(w); end
    end else if (m_st == 1) begin
      if (l) begin m_st = 2; m_clean = 0; m_to = 0; end
    end else if (!l) begin
      m_st = 1; m_ec = 0; m_wc = 0; m_rs = 0;
    end else if (m_st == 2) begin
      m_clean = (m_errq == 0) ? m_clean + 1 : 0;
      m_to++;
      if (m_clean == SWD) m_st = 3;
      else if (m_to == TMO) m_st = 5;
    end else begin
      if (m_win == 0) m_st = 4;
      else if (pc >= LOSS) begin
        m_st = 2; m_clean = 0; m_to = 0;
        m_rs = (m_rs < 255) ? m_rs + 1 : 255;
      end else begin
        m_wc++;
        m_ec = (m_ec + pc > EC_MAX) ? EC_MAX : m_ec + pc;
        if (m_wc == m_win) m_st = 4;
      end
    end
    m_errq = r;
  endtask

  task automatic mchk();
    chk("state", 64'(state), 64'(m_st));
    chk("busy", 64'(busy), 64'(m_st >= 1 && m_st <= 3));
    chk("done", 64'(done), 64'(m_st == 4));
    chk("fail", 64'(fail), 64'(m_st == 5));
    chk("err_count", 64'(err_count), 64'(m_ec));
    chk("word_count", 64'(word_count), 64'(m_wc));
    chk("resync_count", 64'(resync_count), 64'(m_rs));
  endtask

  task automatic cyc(input logic s, input logic a, input logic l,
                     input logic [31:0] w, input logic [31:0] r);
    @(negedge CLK);
    start = s; abort = a; link_ready = l; window_len = w; rx_bit_error = r;
    mstep(s, a, l, w, r);
    @(posedge CLK); #1;
    mchk();
  endtask

  task automatic cyc2(input logic s, input logic l, input logic [31:0] w, input logic [31:0] r);
    @(negedge CLK);
    start2 = s; link_ready2 = l; window_len2 = w; rx_bit_error2 = r;
    @(posedge CLK); #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic s, a, l;
    logic [31:0] w, r;
    int reps, es, ewc, eec, ers;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(input logic s, input logic a, input logic l,
                             input logic [31:0] w, input logic [31:0] r,
                             input int reps, input int es, input int ewc,
                             input int eec, input int ers);
    vec_t t;
    t.s = s; t.a = a; t.l = l; t.w = w; t.r = r;
    t.reps = reps; t.es = es; t.ewc = ewc; t.eec = eec; t.ers = ers;
    return t;
  endfunction

  initial begin
    logic [31:0] rx;
    int pct, rr;
    bit hit;

    mreset();
    repeat (2) @(posedge CLK);
    #1 mchk();                                   // reset state
    @(negedge CLK) RSTn = 1'b1;

    //            s  a  l  win    rx            reps st wc ec rs
    tbl.push_back(v(0, 0, 1, 0,   0,            1,  0, 0, 0, 0));
    tbl.push_back(v(1, 0, 1, 5,   0,            1,  1, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0,   0,            1,  2, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0,   0,            SWD,3, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0,   32'h101,      1,  3, 1, 0, 0));
    tbl.push_back(v(0, 0, 1, 0,   0,            1,  3, 2, 2, 0));
    tbl.push_back(v(0, 0, 1, 0,   32'hFF,       1,  3, 3, 2, 0));
    tbl.push_back(v(0, 0, 1, 0,   0,            1,  2, 3, 2, 1));   // loss
    tbl.push_back(v(0, 0, 1, 0,   0,            SWD,3, 3, 2, 1));
    tbl.push_back(v(0, 0, 1, 0,   0,            1,  3, 4, 2, 1));
    tbl.push_back(v(0, 0, 1, 0,   0,            1,  4, 5, 2, 1));   // last word
    tbl.push_back(v(0, 0, 1, 0,   0,            2,  4, 5, 2, 1));
    tbl.push_back(v(1, 1, 1, 9,   0,            1,  0, 5, 2, 1));   // abort+start
    tbl.push_back(v(1, 0, 1, 0,   0,            1,  1, 0, 0, 0));   // win 0
    tbl.push_back(v(0, 0, 1, 0,   0,            1,  2, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0,   0,            SWD,3, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0,   0,            1,  4, 0, 0, 0));
    tbl.push_back(v(1, 0, 1, 100, 0,            1,  1, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0,   0,            1,  2, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0,   0,            SWD,3, 0, 0, 0));
    tbl.push_back(v(1, 0, 1, 7,   0,            3,  3, 3, 0, 0));   // start ignored
    tbl.push_back(v(0, 0, 0, 0,   0,            1,  1, 0, 0, 0));   // link drop
    tbl.push_back(v(0, 0, 1, 0,   0,            1,  2, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,   0,            1,  1, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 0,   0,            1,  0, 0, 0, 0));
    tbl.push_back(v(1, 0, 1, 2,   0,            1,  1, 0, 0, 0));   // loss on last word
    tbl.push_back(v(0, 0, 1, 0,   0,            1,  2, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0,   0,            SWD,3, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0,   32'hFF,       1,  3, 1, 0, 0));
    tbl.push_back(v(0, 0, 1, 0,   0,            1,  2, 1, 0, 1));
    tbl.push_back(v(0, 0, 1, 0,   0,            SWD,3, 1, 0, 1));
    tbl.push_back(v(0, 0, 1, 0,   0,            1,  4, 2, 0, 1));
    tbl.push_back(v(1, 0, 1, 50,  0,            1,  1, 0, 0, 0));   // abort in MEASURE
    tbl.push_back(v(0, 0, 1, 0,   0,            1,  2, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0,   0,            SWD,3, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0,   32'h3,        2,  3, 2, 2, 0));
    tbl.push_back(v(0, 0, 1, 0,   0,            1,  3, 3, 4, 0));
    tbl.push_back(v(0, 1, 1, 0,   0,            1,  0, 3, 4, 0));

    foreach (tbl[k]) begin
      for (int j = 0; j < tbl[k].reps; j++)
        cyc(tbl[k].s, tbl[k].a, tbl[k].l, tbl[k].w, tbl[k].r);
      chk($sformatf("vec%0d.state", k), 64'(state), 64'(tbl[k].es));
      chk($sformatf("vec%0d.wc", k), 64'(word_count), 64'(tbl[k].ewc));
      chk($sformatf("vec%0d.ec", k), 64'(err_count), 64'(tbl[k].eec));
      chk($sformatf("vec%0d.rs", k), 64'(resync_count), 64'(tbl[k].ers));
    end

    // sync timeout: a nonzero word every 10 cycles keeps sync from forming
    cyc(1, 0, 1, 10, 0);
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < TMO; i++) begin
      rx = (i % 10 == 0) ? ($urandom() | 32'h1) : 32'h0;
      cyc(0, 0, 1, 0, rx);
      if (i == TMO - 2) chk("timeout.pre", 64'(state), 64'd2);
    end
    chk("timeout.state", 64'(state), 64'd5);
    chk("timeout.fail", 64'(fail), 64'd1);
    cyc(0, 0, 1, 0, 0);
    chk("fail.hold", 64'(fail), 64'd1);
    cyc(0, 1, 1, 0, 0);

    // asynchronous reset mid-run, then no activity without a new start
    cyc(1, 0, 1, 30, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (SWD + 3) cyc(0, 0, 1, 0, 0);
    @(negedge CLK); #2 RSTn = 1'b0;
    #1 mreset();
    chk("rst.state", 64'(state), 64'd0);
    chk("rst.wc", 64'(word_count), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    @(negedge CLK) RSTn = 1'b1;
    start = 1'b0; abort = 1'b0; rx_bit_error = '0;
    repeat (3) cyc(0, 0, 1, 0, 0);
    chk("rst.nostart", 64'(state), 64'd0);

    // random traffic against the model
    for (int i = 0; i < 4000 && n_err < 20; i++) begin
      pct = ((i / 500) % 2) ? 25 : 4;
      rr  = $urandom_range(0, 99);
      if (rr >= pct)          rx = 32'h0;
      else if (rr < pct / 2)  rx = 32'h1 << $urandom_range(0, 31);
      else if (rr < pct - 2)  rx = 32'hFF;
      else                    rx = $urandom();
      cyc($urandom_range(0, 99) < 4, $urandom_range(0, 199) == 0,
          $urandom_range(0, 99) < 98, 32'($urandom_range(0, 30)), rx);
    end

    // saturation on a 10-bit error counter
    cyc2(1, 1, 100, 0);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      cyc2(0, 1, 0, 0);
      if (state2 == 3'd3) hit = 1'b1;
    end
    chk("sat.reach_measure", 64'(hit), 64'd1);
    repeat (50) cyc2(0, 1, 0, 32'hFFFF_FFFF);
    chk("sat.ec", 64'(err_count2), 64'd1023);
    chk("sat.wc", 64'(word_count2), 64'd50);
    chk("sat.state", 64'(state2), 64'd3);
    chk("sat.rs", 64'(resync_count2), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
